// File: rtl/hamming_decoder.sv
// rtl/hamming_decoder.sv - SECDED Hamming(16,11) memory-to-memory decoder engine (optional stats: HAMDEC_STATS_EN)
module hamming_decoder #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
`ifdef HAMDEC_STATS_EN
    ,
    output logic [4:0]    single_cnt,
    output logic [4:0]    double_cnt
`endif
);

    localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);
    localparam logic [AW-1:0] SRC_A    = AW'(SRC_BASE);
    localparam logic [AW-1:0] DST_A    = AW'(DST_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_CAP,
        S_DEC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [15:0]     code_q;
    logic [7:0]      res_hi_q;
    logic [AW-1:0]   mem_addr_q;
    logic            mem_wr_en_q;
    logic [7:0]      mem_wr_data_q;
    logic            done_q;
`ifdef HAMDEC_STATS_EN
    logic [4:0]      single_cnt_q;
    logic [4:0]      double_cnt_q;
`endif

    logic [IW-1:0]   idx_nxt;
    logic [AW-1:0]   src_cur;
    logic [AW-1:0]   src_nxt;
    logic [AW-1:0]   dst_cur;

    logic [3:0]      syn_d;
    logic            par_d;
    logic [15:0]     corr_d;
    logic [1:0]      flag_d;
    logic [7:0]      res_hi_d;
    logic [7:0]      res_lo_d;

    // Address arithmetic wraps naturally at 2^AW
    assign idx_nxt = idx_q + IW'(1);
    assign src_cur = SRC_A + (AW'(idx_q) << 1);
    assign src_nxt = SRC_A + (AW'(idx_nxt) << 1);
    assign dst_cur = DST_A + (AW'(idx_q) << 1);

    // Syndrome/parity evaluation, single-bit correction and data extraction
    always_comb begin
        syn_d = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (code_q[k]) begin
                syn_d = syn_d ^ 4'(k);
            end
        end
        par_d  = ^code_q;
        corr_d = code_q;
        flag_d = 2'b00;
        if (par_d) begin
            // Odd overall parity: single error; syndrome 0 means p0 itself flipped
            flag_d = 2'b01;
            if (syn_d != 4'd0) begin
                corr_d[syn_d] = ~code_q[syn_d];
            end
        end else if (syn_d != 4'd0) begin
            // Even parity with nonzero syndrome: uncorrectable double error
            flag_d = 2'b10;
        end
        res_lo_d = {corr_d[12], corr_d[11], corr_d[10], corr_d[9],
                    corr_d[7],  corr_d[6],  corr_d[5],  corr_d[3]};
        res_hi_d = {flag_d, 3'b000, corr_d[15:13]};
    end

    // Control FSM: six states per word, all memory-side outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            idx_q         <= '0;
            code_q        <= '0;
            res_hi_q      <= '0;
            mem_addr_q    <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= '0;
            done_q        <= 1'b0;
`ifdef HAMDEC_STATS_EN
            single_cnt_q  <= '0;
            double_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_RD_LO;
                        idx_q       <= '0;
                        mem_addr_q  <= SRC_A;
                        mem_wr_en_q <= 1'b0;
                        done_q      <= 1'b0;
`ifdef HAMDEC_STATS_EN
                        single_cnt_q <= '0;
                        double_cnt_q <= '0;
`endif
                    end
                end
                S_RD_LO: begin
                    state_q    <= S_RD_HI;
                    mem_addr_q <= src_cur + AW'(1);
                end
                S_RD_HI: begin
                    // Low byte returns the cycle after its address was presented
                    state_q      <= S_CAP;
                    code_q[7:0]  <= mem_rd_data;
                end
                S_CAP: begin
                    state_q      <= S_DEC;
                    code_q[15:8] <= mem_rd_data;
                end
                S_DEC: begin
                    state_q       <= S_WR_LO;
                    res_hi_q      <= res_hi_d;
                    mem_addr_q    <= dst_cur;
                    mem_wr_en_q   <= 1'b1;
                    mem_wr_data_q <= res_lo_d;
`ifdef HAMDEC_STATS_EN
                    if (flag_d == 2'b01 && single_cnt_q != 5'd31) begin
                        single_cnt_q <= single_cnt_q + 5'd1;
                    end
                    if (flag_d == 2'b10 && double_cnt_q != 5'd31) begin
                        double_cnt_q <= double_cnt_q + 5'd1;
                    end
`endif
                end
                S_WR_LO: begin
                    state_q       <= S_WR_HI;
                    mem_addr_q    <= dst_cur + AW'(1);
                    mem_wr_en_q   <= 1'b1;
                    mem_wr_data_q <= res_hi_q;
                end
                S_WR_HI: begin
                    mem_wr_en_q <= 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_RD_LO;
                        idx_q      <= idx_nxt;
                        mem_addr_q <= src_nxt;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    mem_wr_en_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign done        = done_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_data = mem_wr_data_q;
`ifdef HAMDEC_STATS_EN
    assign single_cnt  = single_cnt_q;
    assign double_cnt  = double_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// tb/tb_hamming_decoder.sv - scoreboard testbench for hamming_decoder
module tb_hamming_decoder;

    localparam int NW  = 15;
    localparam int SRC = 30;
    localparam int DST = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
`ifdef HAMDEC_STATS_EN
    logic [4:0] single_cnt;
    logic [4:0] double_cnt;
`endif

    hamming_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
`ifdef HAMDEC_STATS_EN
        ,
        .single_cnt  (single_cnt),
        .double_cnt  (double_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];

    always @(posedge clk) begin
        mem_rd_data <= mem[mem_addr];
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_single;
    int          exp_double;
    logic [15:0] words [NW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference decode built from parity-group masks; returns {hi, lo}
    function automatic logic [15:0] model(input logic [15:0] c);
        int          pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [3:0]  s;
        logic        p;
        logic [15:0] w;
        logic [10:0] dat;
        logic [1:0]  f;
        s = {^(c & 16'hFF00), ^(c & 16'hF0F0), ^(c & 16'hCCCC), ^(c & 16'hAAAA)};
        p = ^c;
        w = c;
        if (p && s != 4'd0) w[s] = ~w[s];
        for (int j = 0; j < 11; j++) dat[j] = w[pos[j]];
        f = p ? 2'b01 : ((s != 4'd0) ? 2'b10 : 2'b00);
        return {f, 3'b000, dat[10:8], dat[7:0]};
    endfunction

    task automatic load_word(input int i, input logic [15:0] w);
        words[i] = w;
        mem[SRC + 2*i]     = w[7:0];
        mem[SRC + 2*i + 1] = w[15:8];
    endtask

    task automatic expect_word(input int i);
        logic [15:0] m;
        wr_t e;
        m = model(words[i]);
        e.a = 8'(DST + 2*i);     e.d = m[7:0];  exp_q.push_back(e);
        e.a = 8'(DST + 2*i + 1); e.d = m[15:8]; exp_q.push_back(e);
        if (m[15:14] == 2'b01) exp_single++;
        if (m[15:14] == 2'b10) exp_double++;
    endtask

    // Output side of the scoreboard: every write must match the next expected byte
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(exp_q.size()), 1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e.a);
                check("wr_data", mem_wr_data, e.d);
            end
        end
    end

    task automatic run(input int hold, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("done_clr_on_start", done, 0);
        if (hold == 0) start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= hold) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic check_stats();
`ifdef HAMDEC_STATS_EN
        check("single_cnt", single_cnt, 32'(exp_single));
        check("double_cnt", double_cnt, 32'(exp_double));
`endif
    endtask

    initial begin
        int cyc;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_done", done, 0);

        // Run 1: clean words, alternating all-zero / all-one
        exp_single = 0; exp_double = 0;
        for (int i = 0; i < NW; i++) begin
            load_word(i, (i % 2 == 1) ? 16'hFFFF : 16'h0000);
            expect_word(i);
        end
        run(0, cyc);
        check("run1_cycles", cyc, 90);
        check("run1_drained", 32'(exp_q.size()), 0);
        check("run1_w1_hi", mem[DST + 3], 8'h07);
        check("run1_w1_lo", mem[DST + 2], 8'hFF);
        check_stats();
        repeat (3) @(posedge clk);
        #1;
        check("done_held", done, 1);

        // Run 2: single, p0-only, double errors then random words; start held mid-run
        exp_single = 0; exp_double = 0;
        load_word(0, 16'hFFDF);
        load_word(1, 16'h0001);
        load_word(2, 16'h0009);
        for (int i = 3; i < NW; i++) load_word(i, 16'($urandom));
        for (int i = 0; i < NW; i++) expect_word(i);
        run(60, cyc);
        check("run2_cycles", cyc, 90);
        check("run2_drained", 32'(exp_q.size()), 0);
        check("single_hi", mem[DST + 1], 8'h47);
        check("single_lo", mem[DST + 0], 8'hFF);
        check("p0_hi", mem[DST + 3], 8'h40);
        check("p0_lo", mem[DST + 2], 8'h00);
        check("double_hi", mem[DST + 5], 8'h80);
        check("double_lo", mem[DST + 4], 8'h01);
        check_stats();

        // Run 3: restart straight from DONE, counters restart from zero
        exp_single = 0; exp_double = 0;
        for (int i = 0; i < NW; i++) expect_word(i);
        run(0, cyc);
        check("run3_cycles", cyc, 90);
        check("run3_drained", 32'(exp_q.size()), 0);
        check_stats();

        // Reset mid-run: only words 0..2 may be written
        for (int a = DST; a < DST + 2*NW; a++) mem[a] = 8'hAA;
        for (int i = 0; i < NW; i++) load_word(i, 16'($urandom));
        for (int i = 0; i < 3; i++) expect_word(i);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_wr_en", mem_wr_en, 0);
        check("abort_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("abort_idle_done", done, 0);
        check("abort_idle_addr", mem_addr, 0);
        check("abort_drained", 32'(exp_q.size()), 0);
        check("abort_w3_lo", mem[DST + 6], 8'hAA);
        check("abort_w3_hi", mem[DST + 7], 8'hAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
